// File: rtl/cnt_pkg.sv
// Shared constants and types for the event counter collector.
// Defines counter count, register addresses, index and FSM enums.
package cnt_pkg;

    localparam int NUM_CNT = 4;

    localparam logic [3:0] ADDR_RX     = 4'h0;
    localparam logic [3:0] ADDR_TX     = 4'h4;
    localparam logic [3:0] ADDR_COLOR  = 4'h8;
    localparam logic [3:0] ADDR_CONFIG = 4'hC;

    typedef enum logic [1:0] {
        IDX_RX     = 2'd0,
        IDX_TX     = 2'd1,
        IDX_COLOR  = 2'd2,
        IDX_CONFIG = 2'd3
    } cnt_idx_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } cnt_state_e;

    function automatic logic [3:0] cnt_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_RX;
            2'd1:    return ADDR_TX;
            2'd2:    return ADDR_COLOR;
            default: return ADDR_CONFIG;
        endcase
    endfunction

endpackage

// File: rtl/cnt_event_collector_arb.sv
// 4-request round-robin arbiter, purely combinational.
// Ports: i_req, i_last_idx -> o_vld, o_idx (first request after last).
module cnt_rr_arb4
    import cnt_pkg::*;
(
    input  logic [NUM_CNT-1:0] i_req,
    input  logic [1:0]         i_last_idx,
    output logic               o_vld,
    output logic [1:0]         o_idx
);

    logic [1:0] w_pos;

    // Walk from lowest to highest priority so the nearest
    // request after i_last_idx is the one left standing.
    always_comb begin
        o_vld = 1'b0;
        o_idx = i_last_idx;
        w_pos = i_last_idx;
        for (int k = 4; k >= 1; k--) begin
            w_pos = i_last_idx + 2'(k);
            if (i_req[w_pos]) begin
                o_vld = 1'b1;
                o_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/cnt_event_collector.sv
// Accumulates event pulses and turns them into RMW counter writes.
// Ports: clk/rst, ev_* pulses, hw_* counter values, host_* in,
//        rgf_* out to register file, pend_ovf sticky flags, busy.
module cnt_event_collector
    import cnt_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PEND_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ev_uart_rx_pkt,
    input  logic                  ev_uart_tx_pkt,
    input  logic                  ev_color_msg,
    input  logic                  ev_config_msg,
    input  logic [DATA_WIDTH-1:0] hw_uart_rx_packets_cnt,
    input  logic [DATA_WIDTH-1:0] hw_uart_tx_packets_cnt,
    input  logic [DATA_WIDTH-1:0] hw_color_msg_cnt,
    input  logic [DATA_WIDTH-1:0] hw_config_msg_cnt,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_wr_en,
    input  logic                  host_rd_en,
    input  logic                  host_sel,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [ADDR_WIDTH-1:0] rgf_addr,
    output logic                  rgf_wr_en,
    output logic                  rgf_rd_en,
    output logic                  rgf_sel,
    output logic [DATA_WIDTH-1:0] rgf_wdata,
    output logic [NUM_CNT-1:0]    pend_ovf,
    output logic                  busy
);

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    cnt_state_e            r_state;
    cnt_state_e            w_state_nxt;
    logic [PEND_WIDTH-1:0] r_pend [NUM_CNT];
    logic [PEND_WIDTH-1:0] r_snap;
    logic [1:0]            r_idx;
    logic [1:0]            r_last_idx;
    logic [NUM_CNT-1:0]    r_ovf;

    logic [NUM_CNT-1:0]    w_ev;
    logic [DATA_WIDTH-1:0] w_hw [NUM_CNT];
    logic                  w_host_act;
    logic                  w_host_wr;
    logic [NUM_CNT-1:0]    w_host_hit;
    logic [NUM_CNT-1:0]    w_pend_nz;
    logic                  w_gnt_vld;
    logic [1:0]            w_gnt_idx;
    logic                  w_eng_wr;
    logic                  w_abandon;
    logic                  w_load;
    logic [PEND_WIDTH-1:0] w_dec [NUM_CNT];
    logic [PEND_WIDTH-1:0] w_base [NUM_CNT];
    logic [PEND_WIDTH-1:0] w_pend_nxt [NUM_CNT];
    logic [NUM_CNT-1:0]    w_ovf_set;

    assign w_ev = {ev_config_msg, ev_color_msg,
                   ev_uart_tx_pkt, ev_uart_rx_pkt};

    assign w_hw[0] = hw_uart_rx_packets_cnt;
    assign w_hw[1] = hw_uart_tx_packets_cnt;
    assign w_hw[2] = hw_color_msg_cnt;
    assign w_hw[3] = hw_config_msg_cnt;

    assign w_host_act = host_sel && (host_wr_en || host_rd_en);
    assign w_host_wr  = host_sel && host_wr_en;

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            w_host_hit[i] = w_host_wr &&
                (host_addr == ADDR_WIDTH'(cnt_addr(2'(i))));
            w_pend_nz[i]  = (r_pend[i] != '0);
        end
    end

    cnt_rr_arb4 u_arb (
        .i_req      (w_pend_nz),
        .i_last_idx (r_last_idx),
        .o_vld      (w_gnt_vld),
        .o_idx      (w_gnt_idx)
    );

    // Host owns the bus whenever it is active; reset suppresses
    // a write that would otherwise go out this cycle.
    assign w_eng_wr  = (r_state == ST_WRITE) && !w_host_act && !rst;
    assign w_abandon = (r_state == ST_WRITE) && w_host_hit[r_idx];

    // Selection also waits out host activity so the snapshot
    // is taken from a pending value the host cannot clear.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld && !w_host_act) begin
                    w_state_nxt = ST_WRITE;
                    w_load      = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!w_host_act || w_abandon)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pending only grows between snapshot and write, so the
    // subtraction cannot underflow.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            w_dec[i] = (w_eng_wr && r_idx == 2'(i)) ? r_snap : '0;
            w_base[i] = r_pend[i] - w_dec[i];
            w_ovf_set[i] = 1'b0;
            if (w_host_hit[i]) begin
                w_pend_nxt[i] = PEND_WIDTH'(w_ev[i]);
            end else if (w_ev[i] && w_base[i] == PEND_MAX) begin
                w_pend_nxt[i] = PEND_MAX;
                w_ovf_set[i]  = 1'b1;
            end else begin
                w_pend_nxt[i] = w_base[i] + PEND_WIDTH'(w_ev[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_snap     <= '0;
            r_idx      <= IDX_RX;
            r_last_idx <= IDX_CONFIG;
            r_ovf      <= '0;
            for (int i = 0; i < NUM_CNT; i++)
                r_pend[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            for (int i = 0; i < NUM_CNT; i++)
                r_pend[i] <= w_pend_nxt[i];
            if (w_load) begin
                r_idx  <= w_gnt_idx;
                r_snap <= r_pend[w_gnt_idx];
            end
            if (w_eng_wr)
                r_last_idx <= r_idx;
        end
    end

    always_comb begin
        rgf_addr  = '0;
        rgf_wr_en = 1'b0;
        rgf_rd_en = 1'b0;
        rgf_sel   = 1'b0;
        rgf_wdata = '0;
        if (w_host_act) begin
            rgf_addr  = host_addr;
            rgf_wr_en = host_wr_en;
            rgf_rd_en = host_rd_en;
            rgf_sel   = host_sel;
            rgf_wdata = host_wdata;
        end else if (w_eng_wr) begin
            rgf_addr  = ADDR_WIDTH'(cnt_addr(r_idx));
            rgf_wr_en = 1'b1;
            rgf_sel   = 1'b1;
            rgf_wdata = w_hw[r_idx] + DATA_WIDTH'(r_snap);
        end
    end

    assign pend_ovf = r_ovf;
    assign busy     = (r_state == ST_WRITE) || (|w_pend_nz);

endmodule
